// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Imported by the arbiter top and its starvation counter.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_CORE,
    OWN_DBG
  } owner_e;

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating starvation counter for the debug port.
// at_max tells the arbiter the debug port must win next.
module dmem_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // clear wins over increment; increment stops at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < MAX_V)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline MEM stage and debug loader.
// Three-cycle IDLE/ISSUE/RESP access with debug starvation guard.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_align
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] core_rd_q, core_rd_d;
  logic [DATA_W-1:0] dbg_rd_q, dbg_rd_d;

  logic dbg_at_max;
  logic dbg_sel;
  logic grant;
  logic dbg_grant;
  logic misalign;
  logic in_issue;
  logic in_resp;
  logic done_any;
  logic ld_resp;

  assign dbg_sel   = dbg_req && (!core_req || dbg_at_max);
  assign grant     = (state_q == ST_IDLE) && (core_req || dbg_req);
  assign dbg_grant = grant && dbg_sel;
  assign misalign  = (addr_q[1:0] != 2'b00);
  assign in_issue  = (state_q == ST_ISSUE);
  assign in_resp   = (state_q == ST_RESP);
  assign done_any  = in_resp || (in_issue && misalign);
  assign ld_resp   = in_resp && !we_q;

  dmem_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .inc   (dbg_req && !dbg_grant),
    .clr   (!dbg_req || dbg_grant),
    .at_max(dbg_at_max)
  );

  // next state, grant latch and load-data capture
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    core_rd_d = core_rd_q;
    dbg_rd_d  = dbg_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ISSUE;
          if (dbg_sel) begin
            owner_d = OWN_DBG;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            owner_d = OWN_CORE;
            we_d    = core_we;
            addr_d  = core_addr;
            wdata_d = core_wdata;
          end
        end
      end
      ST_ISSUE: begin
        state_d = misalign ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!we_q) begin
          if (owner_q == OWN_DBG) begin
            dbg_rd_d = mem_rdata;
          end else begin
            core_rd_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_CORE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      core_rd_q <= '0;
      dbg_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      core_rd_q <= core_rd_d;
      dbg_rd_q  <= dbg_rd_d;
    end
  end

  assign mem_en    = in_issue && !misalign;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign err_align = in_issue && misalign;

  assign core_done = done_any && (owner_q == OWN_CORE);
  assign dbg_done  = done_any && (owner_q == OWN_DBG);

  // load data is forwarded in the done cycle, then held
  assign core_rdata =
    (ld_resp && owner_q == OWN_CORE) ? mem_rdata : core_rd_q;
  assign dbg_rdata =
    (ld_resp && owner_q == OWN_DBG) ? mem_rdata : dbg_rd_q;

  assign core_stall = core_req && !core_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table,
// scoreboard of completions, and multi-cycle corner sequences.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_done, core_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_done;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err_align;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          dbg;
    bit          load;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[12];

  logic [31:0] mem [0:63];

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_done (core_done),
    .core_stall(core_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_done  (dbg_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err_align (err_align)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory: read data one cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (core_done || dbg_done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done actual=%b%b required=none",
                 core_done, dbg_done);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_port_dbg", {31'b0, dbg_done}, {31'b0, e.dbg});
        chk("sb_port_core", {31'b0, core_done}, {31'b0, !e.dbg});
        chk("sb_err", {31'b0, err_align}, {31'b0, e.err});
        if (e.load) begin
          chk(e.dbg ? "sb_dbg_rdata" : "sb_core_rdata",
              e.dbg ? dbg_rdata : core_rdata, e.rdata);
        end
      end
    end
  end

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  function automatic vec_t mk(bit d, bit w, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd,
                              bit er);
    vec_t v;
    v.dbg = d; v.we = w; v.addr = a;
    v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  // one isolated access, started at a negedge with the arbiter idle
  task automatic do_access(input vec_t v);
    exp_t e;
    int cyc;
    int stall_n;
    int en_n;
    bit got;
    e.dbg = v.dbg; e.load = !v.we; e.rdata = v.exp_rd; e.err = v.exp_err;
    sbq.push_back(e);
    if (v.dbg) begin
      dbg_req = 1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      core_req = 1; core_we = v.we;
      core_addr = v.addr; core_wdata = v.wdata;
    end
    #1;
    stall_n = core_stall ? 1 : 0;
    en_n = 0; cyc = 0; got = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        en_n++;
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we", {31'b0, mem_we}, {31'b0, v.we});
        if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
      end
      if (v.dbg ? dbg_done : core_done) begin
        got = 1;
        if (!v.dbg) chk("stall_in_done", {31'b0, core_stall}, 32'd0);
      end else if (core_stall) begin
        stall_n++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
    end
    idle_inputs();
    chk("latency", cyc, v.exp_err ? 32'd1 : 32'd2);
    chk("mem_en_cycles", en_n, v.exp_err ? 32'd0 : 32'd1);
    if (!v.dbg) chk("stall_cycles", stall_n, v.exp_err ? 32'd1 : 32'd2);
    @(negedge clk);
  endtask

  initial begin
    int core_n;
    int dbg_n;
    int cyc;
    vecs[0]  = mk(1, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    vecs[1]  = mk(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 1, 32'h08, 32'h12345678, 32'h0, 0);
    vecs[3]  = mk(1, 0, 32'h08, 32'h0, 32'h12345678, 0);
    vecs[4]  = mk(1, 1, 32'h20, 32'hA5A50F0F, 32'h0, 0);
    vecs[5]  = mk(0, 0, 32'h20, 32'h0, 32'hA5A50F0F, 0);
    vecs[6]  = mk(0, 0, 32'h06, 32'h0, 32'hA5A50F0F, 1);
    vecs[7]  = mk(1, 0, 32'h03, 32'h0, 32'h12345678, 1);
    vecs[8]  = mk(1, 1, 32'h3C, 32'hFFFF0000, 32'h0, 0);
    vecs[9]  = mk(0, 0, 32'h3C, 32'h0, 32'hFFFF0000, 0);
    vecs[10] = mk(0, 1, 32'h11, 32'h55555555, 32'h0, 1);
    vecs[11] = mk(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_core_done", {31'b0, core_done}, 32'd0);
    chk("rst_dbg_done", {31'b0, dbg_done}, 32'd0);
    chk("rst_err", {31'b0, err_align}, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) do_access(vecs[i]);

    // both ports held: core served twice, then debug forced in
    begin
      exp_t e;
      e.dbg = 0; e.load = 1; e.rdata = 32'hDEADBEEF; e.err = 0;
      sbq.push_back(e);
      sbq.push_back(e);
      e.dbg = 1; e.rdata = 32'h12345678;
      sbq.push_back(e);
    end
    core_req = 1; core_addr = 32'h10;
    dbg_req = 1; dbg_addr = 32'h08;
    core_n = 0; dbg_n = 0; cyc = 0;
    while (dbg_n == 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (core_done) core_n++;
      if (dbg_done) dbg_n++;
    end
    idle_inputs();
    chk("starve_core_grants", core_n, 32'd2);
    chk("starve_dbg_done", dbg_n, 32'd1);
    @(negedge clk);

    // core drops req in its done cycle; pending debug goes next
    begin
      exp_t e;
      e.dbg = 0; e.load = 1; e.rdata = 32'hA5A50F0F; e.err = 0;
      sbq.push_back(e);
      e.dbg = 1; e.rdata = 32'hFFFF0000;
      sbq.push_back(e);
    end
    core_req = 1; core_addr = 32'h20;
    dbg_req = 1; dbg_addr = 32'h3C;
    @(negedge clk);
    chk("drop_core_issue_addr", mem_addr, 32'h20);
    @(negedge clk);
    core_req = 0;
    #1;
    chk("drop_core_done", {31'b0, core_done}, 32'd1);
    chk("drop_core_stall", {31'b0, core_stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("drop_dbg_issue_en", {31'b0, mem_en}, 32'd1);
    chk("drop_dbg_issue_addr", mem_addr, 32'h3C);
    @(negedge clk);
    chk("drop_dbg_done", {31'b0, dbg_done}, 32'd1);
    idle_inputs();
    @(negedge clk);

    // reset during the issue cycle of a store aborts it
    do_access(mk(1, 1, 32'h30, 32'h11111111, 32'h0, 0));
    core_req = 1; core_we = 1;
    core_addr = 32'h30; core_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort_issue_en", {31'b0, mem_en}, 32'd1);
    rst = 0;
    idle_inputs();
    #1;
    chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_core_done", {31'b0, core_done}, 32'd0);
    chk("abort_core_rdata", core_rdata, 32'd0);
    chk("abort_dbg_rdata", dbg_rdata, 32'd0);
    @(negedge clk);
    chk("abort_hold_done", {31'b0, core_done}, 32'd0);
    rst = 1;
    do_access(mk(1, 0, 32'h30, 32'h0, 32'h11111111, 0));

    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
